uart_program_loader: RTL and testbench

- Consumes bytes from the UART RX FIFO and assembles them into 32-bit instructions.
- Writes each instruction into the pipeline instruction memory at sequential word addresses.
- Sits between uart_top (RX FIFO side) and the debugger/instruction memory write port.
- A load session is a LOAD command byte, then a program-size byte (N instructions), then 4*N instruction bytes.

---
 rtl/uart_program_loader_pkg.sv | 25 ++
 rtl/uart_program_loader_if.sv | 29 ++
 rtl/uart_program_loader_byte_packer.sv | 56 +++++
 rtl/uart_program_loader.sv | 128 ++++++++++++
 tb/tb_uart_program_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: state encoding,
// default parameter values and a helper for bytes-per-instruction.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SIZE  = 3'd1,
        ST_BYTES = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int          DBIT_DEF     = 8;
    localparam int          INST_SZ_DEF  = 32;
    localparam int          PC_DEF       = 32;
    localparam logic [7:0]  CMD_LOAD_DEF = 8'hFF;

    localparam int BYTES_PER_INST = INST_SZ_DEF / DBIT_DEF;

    // Number of UART bytes that make up one instruction word.
    function automatic int bytes_per_inst(input int inst_sz, input int dbit);
        return inst_sz / dbit;
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Bundles the RX FIFO handshake and instruction-memory write port of the loader.
// master: the loader itself; slave: the surrounding FIFO / memory / debugger side.
interface uart_program_loader_if #(
    parameter int DBIT    = 8,
    parameter int INST_SZ = 32,
    parameter int PC      = 32
);
    logic               i_rx_empty;
    logic [DBIT-1:0]    i_r_data;
    logic               o_rd_uart;
    logic               o_inst_we;
    logic [PC-1:0]      o_inst_addr;
    logic [INST_SZ-1:0] o_inst_data;
    logic               o_busy;
    logic               o_done;
    logic               o_cmd_err;

    modport master (
        input  i_rx_empty, i_r_data,
        output o_rd_uart, o_inst_we, o_inst_addr, o_inst_data,
        output o_busy, o_done, o_cmd_err
    );

    modport slave (
        output i_rx_empty, i_r_data,
        input  o_rd_uart, o_inst_we, o_inst_addr, o_inst_data,
        input  o_busy, o_done, o_cmd_err
    );
endinterface

// File: rtl/uart_program_loader_byte_packer.sv
// Little-endian byte assembler: each load shifts a byte in from the top so
// the first byte of a word ends up in the least significant position.
module byte_packer
    import loader_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int INST_SZ = INST_SZ_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [DBIT-1:0]    byte_i,
    output logic [INST_SZ-1:0] word_o,
    output logic               last_o
);
    localparam int BPI = bytes_per_inst(INST_SZ, DBIT);
    localparam int CW  = (BPI > 1) ? $clog2(BPI) : 1;
    localparam logic [CW-1:0] LAST = CW'(BPI - 1);

    logic [INST_SZ-1:0] word_q, word_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Next shift-register contents and byte count; the count wraps to zero
    // on the final byte so the next word starts clean without a clear.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            if (INST_SZ == DBIT) begin
                word_d = INST_SZ'(byte_i);
            end else begin
                word_d = {byte_i, word_q[INST_SZ-1:DBIT]};
            end
        end
    end

    // Register the assembly word and byte counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;
    assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_program_loader.sv
// Pulls a LOAD / size / payload byte stream out of the UART RX FIFO and
// writes the assembled instructions to sequential instruction-memory words.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int              DBIT     = DBIT_DEF,
    parameter int              INST_SZ  = INST_SZ_DEF,
    parameter int              PC       = PC_DEF,
    parameter logic [DBIT-1:0] CMD_LOAD = DBIT'(CMD_LOAD_DEF)
) (
    input  logic i_clock,
    input  logic i_reset,
    uart_program_loader_if.master bus
);
    localparam logic [PC-1:0] ADDR_STEP = PC'(INST_SZ / 8);

    state_e             state_q, state_d;
    logic [PC-1:0]      addr_q, addr_d;
    logic [DBIT-1:0]    total_q, total_d;
    logic [DBIT-1:0]    cnt_q, cnt_d;
    logic [DBIT-1:0]    cnt_inc;

    logic               pop;
    logic               cmd_err;
    logic               pk_clear;
    logic               pk_load;
    logic               pk_last;
    logic [INST_SZ-1:0] pk_word;

    byte_packer #(
        .DBIT    (DBIT),
        .INST_SZ (INST_SZ)
    ) u_packer (
        .clk_i   (i_clock),
        .rst_ni  (i_reset),
        .clear_i (pk_clear),
        .load_i  (pk_load),
        .byte_i  (bus.i_r_data),
        .word_o  (pk_word),
        .last_o  (pk_last)
    );

    assign cnt_inc = cnt_q + DBIT'(1);

    // Session sequencing: next state, counters and pop/strobe decisions.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        total_d  = total_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        cmd_err  = 1'b0;
        pk_clear = 1'b0;
        pk_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.i_rx_empty) begin
                    pop = 1'b1;
                    if (bus.i_r_data == CMD_LOAD) begin
                        addr_d  = '0;
                        state_d = ST_SIZE;
                    end else begin
                        cmd_err = 1'b1;
                    end
                end
            end
            ST_SIZE: begin
                if (!bus.i_rx_empty) begin
                    pop     = 1'b1;
                    total_d = bus.i_r_data;
                    if (bus.i_r_data == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d    = '0;
                        pk_clear = 1'b1;
                        state_d  = ST_BYTES;
                    end
                end
            end
            ST_BYTES: begin
                if (!bus.i_rx_empty) begin
                    pop     = 1'b1;
                    pk_load = 1'b1;
                    if (pk_last) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_STEP;
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == total_q) ? ST_DONE : ST_BYTES;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, address and instruction-count registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            total_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            total_q <= total_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pop and error strobes are combinational from the FIFO flag, so they are
    // gated with reset to keep every output low while reset is held.
    assign bus.o_rd_uart   = pop & i_reset;
    assign bus.o_cmd_err   = cmd_err & i_reset;
    assign bus.o_inst_we   = (state_q == ST_WRITE);
    assign bus.o_done      = (state_q == ST_DONE);
    assign bus.o_busy      = (state_q != ST_IDLE);
    assign bus.o_inst_addr = addr_q;
    assign bus.o_inst_data = pk_word;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: a queue-based FIFO model feeds bytes,
// expected writes go into a scoreboard queue and a monitor checks every write.
module tb_uart_program_loader;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_program_loader_if #(.DBIT(8), .INST_SZ(32), .PC(32)) bus ();

    uart_program_loader #(
        .DBIT     (8),
        .INST_SZ  (32),
        .PC       (32),
        .CMD_LOAD (8'hFF)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] fifo[$];
    wr_t        exp_q[$];
    logic       pop_pending = 1'b0;
    int         cyc = 0;
    int         last_pop_cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         wr_cnt = 0;
    int         gap_pops = 0;
    bit         in_gap = 0;
    bit         chk_done_lat = 0;
    bit         prev_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bytes(input logic [7:0] b[]);
        foreach (b[i]) fifo.push_back(b[i]);
    endtask

    // Wait until the FIFO is drained and the loader is back in IDLE.
    task automatic wait_idle(input string name, input int max_cyc);
        bit ok = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (fifo.size() == 0 && !bus.o_busy) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: loader still busy=%0b fifo=%0d after %0d cycles",
                     name, bus.o_busy, fifo.size(), max_cyc);
        end
    endtask

    task automatic wait_fifo_empty(input string name, input int max_cyc);
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (fifo.size() == 0) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: fifo still holds %0d bytes", name, fifo.size());
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: apply the previous pop and present the head at the negedge,
    // then sample the pop request well before the next rising edge.
    initial begin
        bus.i_rx_empty = 1'b1;
        bus.i_r_data   = '0;
        forever begin
            @(negedge clk);
            if (pop_pending && fifo.size() > 0) void'(fifo.pop_front());
            bus.i_rx_empty = (fifo.size() == 0);
            bus.i_r_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
            #4;
            pop_pending = bus.o_rd_uart;
            if (bus.o_rd_uart) last_pop_cyc = cyc;
        end
    end

    // Monitor: compares each write against the scoreboard and tallies pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_inst_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             bus.o_inst_addr, bus.o_inst_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", bus.o_inst_addr, e.addr);
                    check("write_data", bus.o_inst_data, e.data);
                    check("write_latency", cyc - last_pop_cyc, 1);
                end
            end
            if (bus.o_done) begin
                done_cnt++;
                check("busy_with_done", bus.o_busy, 1);
                if (chk_done_lat) begin
                    check("done_latency_in_range",
                          (cyc - last_pop_cyc >= 1) && (cyc - last_pop_cyc <= 2), 1);
                end
            end
            if (prev_done) check("busy_after_done", bus.o_busy, 0);
            prev_done = bus.o_done;
            if (bus.o_cmd_err) err_cnt++;
            if (in_gap && bus.o_rd_uart) gap_pops++;
        end else begin
            prev_done = 0;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(bus.o_rd_uart && bus.i_rx_empty))
        else $error("pop while FIFO empty");
    assert property (@(posedge clk) disable iff (!rst_n) bus.o_inst_we |=> !bus.o_inst_we)
        else $error("write enable held for two cycles");

    initial begin
        int d0, e0;

        // Reset state with a byte waiting in the FIFO: nothing may be popped.
        fifo.push_back(8'h55);
        repeat (3) @(negedge clk);
        #1;
        check("reset_rd_uart", bus.o_rd_uart, 0);
        check("reset_inst_we", bus.o_inst_we, 0);
        check("reset_addr", bus.o_inst_addr, 0);
        check("reset_data", bus.o_inst_data, 0);
        check("reset_busy", bus.o_busy, 0);
        check("reset_done", bus.o_done, 0);
        check("reset_cmd_err", bus.o_cmd_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("stale_byte", 20);
        check("stale_byte_cmd_err", err_cnt, 1);

        // Two-instruction session.
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back('{addr: 32'h0, data: 32'h0A0A0A03});
        exp_q.push_back('{addr: 32'h4, data: 32'h0A0A0A0A});
        push_bytes('{8'hFF, 8'h02, 8'h03, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A});
        wait_idle("two_inst", 200);
        check("two_inst_done", done_cnt - d0, 1);
        check("two_inst_no_err", err_cnt - e0, 0);
        check("two_inst_drained", exp_q.size(), 0);

        // Empty program.
        d0 = done_cnt;
        chk_done_lat = 1;
        push_bytes('{8'hFF, 8'h00});
        wait_idle("size_zero", 50);
        chk_done_lat = 0;
        check("size_zero_done", done_cnt - d0, 1);

        // Junk byte then a one-instruction session.
        d0 = done_cnt; e0 = err_cnt;
        exp_q.push_back('{addr: 32'h0, data: 32'h44332211});
        push_bytes('{8'h55, 8'hFF, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
        wait_idle("junk_then_load", 100);
        check("junk_cmd_err", err_cnt - e0, 1);
        check("junk_done", done_cnt - d0, 1);
        check("junk_drained", exp_q.size(), 0);

        // Stall mid-instruction for 100 cycles.
        d0 = done_cnt;
        exp_q.push_back('{addr: 32'h0, data: 32'hDDCCBBAA});
        push_bytes('{8'hFF, 8'h01, 8'hAA, 8'hBB});
        wait_fifo_empty("stall_fill", 50);
        in_gap = 1;
        gap_pops = 0;
        repeat (100) @(negedge clk);
        in_gap = 0;
        check("stall_no_pop", gap_pops, 0);
        check("stall_busy", bus.o_busy, 1);
        check("stall_no_write_yet", exp_q.size(), 1);
        push_bytes('{8'hCC, 8'hDD});
        wait_idle("stall_resume", 100);
        check("stall_done", done_cnt - d0, 1);
        check("stall_drained", exp_q.size(), 0);

        // Reset in the middle of the second instruction.
        d0 = done_cnt;
        exp_q.push_back('{addr: 32'h0, data: 32'h04030201});
        push_bytes('{8'hFF, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        wait_fifo_empty("midreset_fill", 50);
        repeat (3) @(negedge clk);
        check("midreset_first_write", exp_q.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_rd_uart", bus.o_rd_uart, 0);
        check("midreset_inst_we", bus.o_inst_we, 0);
        check("midreset_addr", bus.o_inst_addr, 0);
        check("midreset_data", bus.o_inst_data, 0);
        check("midreset_busy", bus.o_busy, 0);
        check("midreset_done", bus.o_done, 0);
        check("midreset_cmd_err", bus.o_cmd_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midreset_no_done", done_cnt - d0, 0);
        exp_q.push_back('{addr: 32'h0, data: 32'hEFBEADDE});
        push_bytes('{8'hFF, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        wait_idle("after_reset", 100);
        check("after_reset_done", done_cnt - d0, 1);
        check("after_reset_drained", exp_q.size(), 0);

        check("total_writes", wr_cnt, 6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
